// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the team UART link.
// Frame on the wire: start(0), 8 data bits LSB first, even parity, stop(1).
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for the asynchronous RxD pin.
// Both flops reset to 1 so that reset looks like an idle line, not a start bit.
module uart_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises RxD, validates the start bit, samples each bit at
// mid-bit and reports the byte with a one-cycle valid plus parity/framing flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] RxData,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int MID   = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(MID);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_t            state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par, par_n;
  logic                 bit_tick;
  logic                 done;

  uart_sync u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (RxD),
    .q    (rxs)
  );

  // Once past the start bit, cnt runs 0..CLKS_PER_BIT-1 so every sample lands one bit apart.
  assign bit_tick = (cnt == LAST_CNT);
  assign busy     = (state != IDLE);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par;
    done      = 1'b0;

    case (state)
      IDLE: begin
        if (rxs == START_BIT) begin
          bit_cnt_n = '0;
          // With MID=0 the first low clock is already the start-bit sample.
          if (MID == 0) begin
            state_n = DATA;
            cnt_n   = '0;
          end else begin
            state_n = START;
            cnt_n   = CNT_ONE;
          end
        end
      end

      START: begin
        if (cnt == MID_CNT) begin
          cnt_n   = '0;
          state_n = (rxs == START_BIT) ? DATA : IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      DATA: begin
        if (bit_tick) begin
          cnt_n     = '0;
          shreg_n   = {rxs, shreg[DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt + BIT_W'(1);
          if (bit_cnt == LAST_BIT) state_n = PARITY;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      PARITY: begin
        if (bit_tick) begin
          cnt_n   = '0;
          par_n   = rxs;
          state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      STOP: begin
        if (bit_tick) begin
          cnt_n   = '0;
          done    = 1'b1;
          state_n = (rxs == STOP_BIT) ? IDLE : WAIT_IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      WAIT_IDLE: begin
        if (rxs == STOP_BIT) state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Result registers only move on the stop sample, so the flags persist until the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      RxData     <= 8'h00;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par     <= par_n;
      valid   <= done;
      if (done) begin
        RxData     <= shreg;
        parity_err <= par ^ (^shreg);
        frame_err  <= (rxs != STOP_BIT);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 1 and 16 clocks per bit; every valid pulse is
// logged and compared against frames predicted from the wire-level frame rules.
module tb_uart_rx;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } rec_t;

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       sbit;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx1 = 1'b1;
  logic       rx16 = 1'b1;
  logic [7:0] data1, data16;
  logic       valid1, valid16, pe1, pe16, fe1, fe16, busy1, busy16;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  rec_t obsq[$];
  rec_t expq[$];

  uart_rx #(.CLKS_PER_BIT(1)) dut (
    .clk(clk), .reset(reset), .RxD(rx1), .RxData(data1), .valid(valid1),
    .parity_err(pe1), .frame_err(fe1), .busy(busy1)
  );

  uart_rx #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .reset(reset), .RxD(rx16), .RxData(data16), .valid(valid16),
    .parity_err(pe16), .frame_err(fe16), .busy(busy16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid1)  obsq.push_back('{cyc: cyc, data: data1,  pe: pe1,  fe: fe1});
    if (valid16) obsq.push_back('{cyc: cyc, data: data16, pe: pe16, fe: fe16});
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic driveLine(input bit wide, input logic v);
    if (wide) rx16 = v;
    else      rx1 = v;
  endtask

  // Expected result of one frame whose start bit was driven just after edge e0.
  function automatic rec_t modelFrame(input int e0, input bit wide, input logic [7:0] d,
                                      input logic p, input logic s);
    int   cpb;
    rec_t r;
    cpb    = wide ? 16 : 1;
    r.cyc  = e0 + 3 + (cpb - 1) / 2 + 10 * cpb;
    r.data = d;
    r.pe   = p ^ (^d);
    r.fe   = !s;
    return r;
  endfunction

  // Drives a whole frame; returns with the stop-bit value still on the line.
  task automatic applyStimulus(input bit wide, input logic [7:0] d, input logic p,
                               input logic s, output int e0);
    logic [10:0] frame;
    int          cpb;
    cpb   = wide ? 16 : 1;
    frame = {s, p, d, 1'b0};
    e0    = cyc;
    for (int i = 0; i < 11; i++) begin
      driveLine(wide, frame[i]);
      step(cpb);
    end
  endtask

  task automatic checkFrames(input string tag);
    int n;
    checkOutput({tag, "_count"}, obsq.size(), expq.size());
    n = (obsq.size() < expq.size()) ? obsq.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_cyc%0d", tag, i),  obsq[i].cyc,  expq[i].cyc);
      checkOutput($sformatf("%s_data%0d", tag, i), obsq[i].data, expq[i].data);
      checkOutput($sformatf("%s_pe%0d", tag, i),   obsq[i].pe,   expq[i].pe);
      checkOutput($sformatf("%s_fe%0d", tag, i),   obsq[i].fe,   expq[i].fe);
    end
    obsq.delete();
    expq.delete();
  endtask

  vec_t       vecs[8];
  rec_t       r;
  int         e0;
  logic [7:0] d;
  logic       p, s;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 3, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 0, 8'h01, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 2, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, 2, 8'h3C, 1'b1, 1'b0};
    vecs[4] = '{8'h5A, 1'b0, 1'b1, 2, 8'h5A, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 0, 8'h80, 1'b0, 1'b0};
    vecs[7] = '{8'h7E, 1'b1, 1'b1, 1, 8'h7E, 1'b1, 1'b0};

    step(3);
    checkOutput("rst_data",  data1, 8'h00);
    checkOutput("rst_valid", valid1, 1'b0);
    checkOutput("rst_pe",    pe1, 1'b0);
    checkOutput("rst_fe",    fe1, 1'b0);
    checkOutput("rst_busy",  busy1, 1'b0);
    checkOutput("rst_busy16", busy16, 1'b0);
    reset = 1'b0;
    step(4);

    // Table of frames at one bit per clock, some back-to-back.
    foreach (vecs[i]) begin
      applyStimulus(1'b0, vecs[i].data, vecs[i].pbit, vecs[i].sbit, e0);
      r      = modelFrame(e0, 1'b0, vecs[i].data, vecs[i].pbit, vecs[i].sbit);
      r.data = vecs[i].exp_data;
      r.pe   = vecs[i].exp_pe;
      r.fe   = vecs[i].exp_fe;
      expq.push_back(r);
      step(vecs[i].gap);
    end
    step(8);
    checkFrames("table");
    checkOutput("table_busy", busy1, 1'b0);

    // Parity error persists until the next clean frame.
    step(20);
    checkOutput("pe_hold", pe1, 1'b1);
    applyStimulus(1'b0, 8'h5A, 1'b0, 1'b1, e0);
    expq.push_back(modelFrame(e0, 1'b0, 8'h5A, 1'b0, 1'b1));
    step(8);
    checkFrames("pe_clear");
    checkOutput("pe_cleared", pe1, 1'b0);

    // Break: stop bit 0 and line held low.
    applyStimulus(1'b0, 8'h77, 1'b0, 1'b0, e0);
    expq.push_back(modelFrame(e0, 1'b0, 8'h77, 1'b0, 1'b0));
    step(30);
    checkOutput("break_busy", busy1, 1'b1);
    driveLine(1'b0, 1'b1);
    step(6);
    checkOutput("break_idle", busy1, 1'b0);
    checkFrames("break");
    applyStimulus(1'b0, 8'h5A, 1'b0, 1'b1, e0);
    expq.push_back(modelFrame(e0, 1'b0, 8'h5A, 1'b0, 1'b1));
    step(8);
    checkFrames("after_break");

    // 16 clocks per bit: a short glitch, then a full frame.
    driveLine(1'b1, 1'b0);
    step(5);
    driveLine(1'b1, 1'b1);
    step(1);
    checkOutput("glitch_busy", busy16, 1'b1);
    step(40);
    checkOutput("glitch_idle", busy16, 1'b0);
    checkOutput("glitch_frames", obsq.size(), 0);
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b1, e0);
    expq.push_back(modelFrame(e0, 1'b1, 8'hC3, 1'b0, 1'b1));
    step(8);
    checkFrames("c3");

    // Reset in the middle of a frame, after leaving non-zero results behind.
    applyStimulus(1'b0, 8'h3C, 1'b1, 1'b1, e0);
    expq.push_back(modelFrame(e0, 1'b0, 8'h3C, 1'b1, 1'b1));
    step(8);
    checkFrames("pre_reset");
    begin
      logic [10:0] frame;
      frame = {1'b1, 1'b0, 8'h81, 1'b0};
      for (int i = 0; i < 6; i++) begin
        driveLine(1'b0, frame[i]);
        step(1);
      end
    end
    reset = 1'b1;
    driveLine(1'b0, 1'b1);
    #1;
    checkOutput("mid_rst_data",  data1, 8'h00);
    checkOutput("mid_rst_pe",    pe1, 1'b0);
    checkOutput("mid_rst_fe",    fe1, 1'b0);
    checkOutput("mid_rst_valid", valid1, 1'b0);
    checkOutput("mid_rst_busy",  busy1, 1'b0);
    step(2);
    reset = 1'b0;
    step(20);
    checkOutput("mid_rst_frames", obsq.size(), 0);
    applyStimulus(1'b0, 8'h81, 1'b0, 1'b1, e0);
    expq.push_back(modelFrame(e0, 1'b0, 8'h81, 1'b0, 1'b1));
    step(8);
    checkFrames("after_reset");

    // Random frames: occasional bad parity and bad stop bits.
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 5) != 0);
      applyStimulus(1'b0, d, p, s, e0);
      expq.push_back(modelFrame(e0, 1'b0, d, p, s));
      if (!s) begin
        step($urandom_range(0, 4));
        driveLine(1'b0, 1'b1);
        step($urandom_range(1, 3));
      end else begin
        step($urandom_range(0, 3));
      end
    end
    step(8);
    checkFrames("rand1");

    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      applyStimulus(1'b1, d, p, 1'b1, e0);
      expq.push_back(modelFrame(e0, 1'b1, d, p, 1'b1));
      step($urandom_range(0, 20));
    end
    step(8);
    checkFrames("rand16");
    checkOutput("final_busy16", busy16, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the team's UART link. It is the far end of the 11-bit transmitter frame: start bit 0, eight data bits LSB first, an even-parity bit equal to the XOR of the data, then stop bit 1.
- It synchronises the line, finds and validates the start bit, and samples each bit at mid-bit.
- On every stop-bit sample it presents the byte with a one-cycle valid strobe, plus parity and framing error flags.
- It sits between the board RxD pin and the consumer logic.

Parameters:
- CLKS_PER_BIT, 1, clocks per serial bit (≥1). The default 1 matches the transmitter's one-bit-per-clock rate.
- MID, (CLKS_PER_BIT-1)/2, localparam giving the clock within a bit at which the line is sampled.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- RxD  in  1  serial line, asynchronous, idles high
- RxData  out  8  last received byte
- valid  out  1  one-cycle strobe: RxData and the flags are updated
- parity_err  out  1  received parity bit != ^RxData; qualified by valid
- frame_err  out  1  stop bit sampled 0; qualified by valid
- busy  out  1  frame reception in progress

Behaviour:
- Interface (already decided): reset is asynchronous and active-high; clock is clk; all state is on posedge clk.
- Reset values:
  - RxData = 0x00; valid, parity_err, frame_err, busy = 0.
  - FSM in IDLE; synchroniser flops = 1.
  - Reset asserted mid-frame aborts the frame with no valid pulse.
- Synchroniser: two flops on RxD, giving rxs. All logic uses rxs only.
- Edge naming: E0 is the edge after which RxD goes low. D = E0+3 is the first edge at which the FSM sees rxs=0. D is clock 0 of the start bit.
- Sample timing:
  - Start bit is sampled at D+MID.
  - Bit k (k=1..10: data0..7, parity, stop) is sampled at D+MID+k*CLKS_PER_BIT.
  - The bit-clock counter is ceil(log2(CLKS_PER_BIT+1)) bits wide and resets to 0 at every sample.
- FSM states and transitions:
  - IDLE: rxs=0 → START with busy=1. With MID=0 the start sample is taken at this same edge.
  - START: sample=1 → false start, back to IDLE, busy=0, no valid. Sample=0 → DATA.
  - DATA: shift the sample into bit [7] of the shift register, shifting right, so LSB arrives first. After 8 samples → PARITY.
  - PARITY: store the parity bit → STOP.
  - STOP: at the stop-sample edge, load RxData from the shift register, assert valid=1 for exactly one cycle, and set parity_err = p ^ (^data) and frame_err = ~stop.
    - Stop=1 → IDLE with busy=0.
    - Stop=0 → WAIT_IDLE.
- WAIT_IDLE: busy stays 1 until rxs=1, then → IDLE. A held-low break produces one frame_err and no further frames.
- Flag persistence: parity_err and frame_err hold their values until the next valid.
- Back-to-back frames:
  - IDLE is re-entered at the stop-sample edge, so a start bit immediately after the stop bit is detected with no gap.
  - With CLKS_PER_BIT=1 this gives one byte every 11 clocks.
- Latency: with CLKS_PER_BIT=1, valid is high in the cycle after E13. In general that edge is E0+3+MID+10*CLKS_PER_BIT.
- Glitches: a low pulse shorter than MID+1 clocks is rejected as a false start.

Decomposition:
- Shared package uart_pkg holds:
  - DATA_BITS=8, FRAME_BITS=11
  - START_BIT=1'b0, STOP_BIT=1'b1
  - the rx state enum {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE}
- One sub-module: uart_sync, a 2-flop synchroniser with a reset value of 1.

Test Plan:
- Loopback, CLKS_PER_BIT=1: transmitter sends 0xA5 (parity 0) → single valid pulse at E13; RxData=0xA5, parity_err=0, frame_err=0, busy=0 afterwards.
- Back-to-back 0x01 then 0xFF (parity 1, 0): valid at E13 and E24; RxData 0x01 then 0xFF; no errors.
- Corrupted parity: send 0x3C with parity bit 1 → valid, RxData=0x3C, parity_err=1. The next clean frame clears parity_err.
- Stop bit forced 0, line then held low 30 clocks → exactly one valid with frame_err=1; busy=1 until the line returns high; a following 0x5A frame is received cleanly.
- CLKS_PER_BIT=16: a 5-clock low glitch → no valid, busy returns to 0. A full 0xC3 frame → valid at E0+170, RxData=0xC3.
- Reset asserted at E6 mid-frame → all outputs 0 immediately, no valid. A frame of 0x81 sent after release is received correctly.
